// File: rtl/top_level.sv
// Pattern-search engine: scans a 32-byte message in data memory for a 5-bit pattern
// and writes back the in-byte, per-byte and whole-string match counts.

module win_match #(
    parameter int W = 5
) (
    input  logic [W-1:0] win,
    input  logic [W-1:0] pat,
    output logic         hit
);
    assign hit = (win == pat);
endmodule

module dat_mem #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data
);
    // No reset: contents are preloaded externally and must survive the start pulse.
    logic [DW-1:0] core [0:2**AW-1];

    always_ff @(posedge clk)
        if (wr_en) core[addr] <= wr_data;

    assign rd_data = core[addr];
endmodule

module top_level #(
    parameter int DW     = 8,
    parameter int AW     = 8,
    parameter int NBYTES = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    output logic done
);
    localparam int PW   = 5;
    localparam int HW   = PW - 1;
    localparam int NWIN = DW;
    localparam int NIN  = DW - PW + 1;
    localparam int IW   = $clog2(NBYTES);
    localparam logic [AW-1:0] PAT_ADDR = AW'(NBYTES);

    typedef enum logic [2:0] {LOAD_PAT, SCAN, WR33, WR34, WR35, IDLE} state_t;

    state_t         state, next;
    logic [PW-1:0]  pat;
    logic [IW-1:0]  idx;
    logic [HW-1:0]  hist;
    logic [7:0]     ctb, cto, cts;
    logic [7:0]     byte_hits, all_hits, cts_add;
    logic           wr_en;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wr_data, rd_data;
    logic [DW+HW-1:0] x;
    logic [NWIN-1:0]  hits;

    dat_mem #(.DW(DW), .AW(AW)) dm1 (
        .clk     (clk),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    // Windows 0..NIN-1 lie inside the current byte; the rest straddle the previous byte's tail.
    assign x = {hist, rd_data};

    for (genvar k = 0; k < NWIN; k++) begin : g_win
        win_match #(.W(PW)) u_win (
            .win (x[k+PW-1:k]),
            .pat (pat),
            .hit (hits[k])
        );
    end

    always_comb begin
        byte_hits = '0;
        all_hits  = '0;
        for (int k = 0; k < NWIN; k++) begin
            if (k < NIN) byte_hits = byte_hits + 8'(hits[k]);
            all_hits = all_hits + 8'(hits[k]);
        end
        cts_add = (idx == '0) ? byte_hits : all_hits;
    end

    always_comb begin
        next    = state;
        wr_en   = 1'b0;
        addr    = PAT_ADDR;
        wr_data = ctb;
        case (state)
            LOAD_PAT: next = SCAN;
            SCAN: begin
                addr = AW'(idx);
                if (idx == IW'(NBYTES - 1)) next = WR33;
            end
            WR33: begin
                addr  = PAT_ADDR + AW'(1);
                wr_en = !req;
                next  = WR34;
            end
            WR34: begin
                addr    = PAT_ADDR + AW'(2);
                wr_data = cto;
                wr_en   = !req;
                next    = WR35;
            end
            WR35: begin
                addr    = PAT_ADDR + AW'(3);
                wr_data = cts;
                wr_en   = !req;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD_PAT;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
            done  <= 1'b0;
            idx   <= '0;
            hist  <= '0;
            pat   <= '0;
        end else if (req) begin
            state <= LOAD_PAT;
            ctb   <= '0;
            cto   <= '0;
            cts   <= '0;
            done  <= 1'b0;
            idx   <= '0;
            hist  <= '0;
            pat   <= '0;
        end else begin
            state <= next;
            case (state)
                LOAD_PAT: begin
                    pat  <= rd_data[DW-1:DW-PW];
                    hist <= '0;
                    idx  <= '0;
                end
                SCAN: begin
                    ctb  <= ctb + byte_hits;
                    cto  <= cto + 8'(byte_hits != '0);
                    cts  <= cts + cts_add;
                    hist <= rd_data[HW-1:0];
                    idx  <= idx + 1'b1;
                end
                IDLE:    done <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for the pattern-search engine: string-level count model plus
// a per-cycle done-timing check.

module tb_top_level;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0;
    logic done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cnt = 0;

    logic [7:0] msg [0:31];
    logic [7:0] pbyte;

    top_level dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Edges since the last start; results are due on the 37th.
    always @(posedge clk or posedge reset) begin
        if (reset)          cnt <= 0;
        else if (req)       cnt <= 0;
        else if (cnt < 1000) cnt <= cnt + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_done;
            exp_done = !reset && (cnt >= 37);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL done_cycle t=%0t cnt=%0d got %b exp %b", $time, cnt, done, exp_done);
            end
        end
    end

    // Counts taken straight from the string definition of the three results.
    task automatic model(output int ctb, output int cto, output int cts);
        logic [255:0] s;
        logic [4:0]   p;
        bit           hitb [32];
        for (int b = 0; b < 32; b++) begin
            s[255-8*b -: 8] = msg[b];
            hitb[b] = 1'b0;
        end
        p = pbyte[7:3];
        ctb = 0; cto = 0; cts = 0;
        for (int j = 0; j < 252; j++) begin
            if (s[255-j -: 5] == p) begin
                cts++;
                if ((j % 8) <= 3) begin
                    ctb++;
                    hitb[j/8] = 1'b1;
                end
            end
        end
        for (int b = 0; b < 32; b++) cto += int'(hitb[b]);
    endtask

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    // mode: 0 start by reset, 1 by req, 2 both; restart_at > 0 re-issues req mid-scan.
    task automatic run_case(input string name, input int mode, input int restart_at,
                            input int lctb, input int lcto, input int lcts);
        int mctb, mcto, mcts, n;
        bit intact;
        @(posedge clk); #2;
        for (int i = 0; i < 32; i++) dut.dm1.core[i] <= msg[i];
        dut.dm1.core[32] <= pbyte;
        dut.dm1.core[33] <= 8'hEE;
        dut.dm1.core[34] <= 8'hEE;
        dut.dm1.core[35] <= 8'hEE;
        if (mode != 1) reset = 1'b1;
        if (mode != 0) req = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        req   = 1'b0;
        if (restart_at > 0) begin
            repeat (restart_at) begin @(posedge clk); #2; end
            req = 1'b1;
            @(posedge clk); #2;
            req = 1'b0;
        end
        n = 0;
        while (!done && n < 45) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout got done=%b after %0d cycles exp 1", name, done, n);
        end
        model(mctb, mcto, mcts);
        if (lctb >= 0) begin
            cmp({name, "_model_ctb"}, mctb, lctb);
            cmp({name, "_model_cto"}, mcto, lcto);
            cmp({name, "_model_cts"}, mcts, lcts);
        end
        cmp({name, "_ctb"}, int'(dut.dm1.core[33]), mctb);
        cmp({name, "_cto"}, int'(dut.dm1.core[34]), mcto);
        cmp({name, "_cts"}, int'(dut.dm1.core[35]), mcts);
        intact = 1'b1;
        for (int i = 0; i < 32; i++) if (dut.dm1.core[i] !== msg[i]) intact = 1'b0;
        if (dut.dm1.core[32] !== pbyte) intact = 1'b0;
        cmp({name, "_mem_intact"}, int'(intact), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk_en = 1'b1;
        #4;
        cmp("reset_done", int'(done), 0);

        for (int i = 0; i < 32; i++) msg[i] = 8'h00;
        pbyte = 8'h00;
        run_case("zeros", 0, 0, 128, 32, 252);

        for (int i = 0; i < 32; i++) msg[i] = 8'h55;
        pbyte = 8'hA8;
        run_case("alt", 1, 0, 64, 32, 126);

        for (int i = 0; i < 32; i++) msg[i] = 8'hFF;
        pbyte = 8'h00;
        run_case("ones", 2, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) msg[i] = 8'h00;
        msg[0] = 8'h07;
        msg[1] = 8'hC0;
        pbyte = 8'hF8;
        run_case("cross", 1, 0, 0, 0, 1);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 32; i++) msg[i] = 8'($urandom_range(0, 255));
            pbyte = 8'($urandom_range(0, 255));
            run_case($sformatf("rand%0d", r), r % 2, 0, -1, -1, -1);
        end

        for (int i = 0; i < 32; i++) msg[i] = 8'h00;
        pbyte = 8'h00;
        run_case("restart", 1, 15, 128, 32, 252);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish exp finish before 200000");
        $fatal(1, "watchdog");
    end
endmodule
